// File: rtl/leaf_stream_fifo.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// leaf_stream_fifo
//   Elastic first-word-fall-through buffer placed in front of the MyLeaf
//   pass-through stage. Words arrive on a valid/ready handshake, are held in
//   a DEPTH-entry circular store, and leave in arrival order on out_bits,
//   which drives the leaf's 'inn' input.
//
// Ports
//   clock      : single clock, all state changes on its rising edge
//   reset      : asynchronous assert, active-low (0 = in reset)
//   in_valid   : producer offers in_bits
//   in_ready   : buffer can take a word this cycle (depends on state only)
//   in_bits    : write data, WIDTH bits
//   out_valid  : out_bits holds the oldest stored word
//   out_ready  : consumer takes out_bits this cycle
//   out_bits   : oldest stored word (zero while empty), WIDTH bits
//   count      : number of words currently stored
// -----------------------------------------------------------------------------
module leaf_stream_fifo #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_bits,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_bits,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [AW-1:0] PTR_ZERO = AW'(0);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    // Pointer arithmetic relies on natural wrap, so DEPTH must be a power of two.
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("leaf_stream_fifo: DEPTH must be a power of two and at least 2");
    end

    // Storage (intentionally not reset) and state registers.
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             in_ready_r;
    logic             out_valid_r;

    // Next-state values.
    logic             push_s;
    logic             pop_s;
    logic [AW-1:0]    wr_ptr_nxt_s;
    logic [AW-1:0]    rd_ptr_nxt_s;
    logic [CW-1:0]    count_nxt_s;
    logic             in_ready_nxt_s;
    logic             out_valid_nxt_s;
    logic [WIDTH-1:0] out_bits_s;

    // Handshake qualification and next-state computation.
    always_comb begin
        push_s          = in_valid & in_ready_r;
        pop_s           = out_valid_r & out_ready;
        wr_ptr_nxt_s    = wr_ptr_r;
        rd_ptr_nxt_s    = rd_ptr_r;
        count_nxt_s     = count_r;

        if (push_s) begin
            wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end

        if (pop_s) begin
            rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end

        // Push and pop together leave the occupancy unchanged.
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase

        // Flags are precomputed from the next occupancy so they can be
        // registered while still reflecting the count after this edge.
        in_ready_nxt_s  = (count_nxt_s != CNT_FULL);
        out_valid_nxt_s = (count_nxt_s != CNT_ZERO);
    end

    // Pointer, occupancy and flag registers; reset empties the buffer at once.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_r    <= PTR_ZERO;
            rd_ptr_r    <= PTR_ZERO;
            count_r     <= CNT_ZERO;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            wr_ptr_r    <= wr_ptr_nxt_s;
            rd_ptr_r    <= rd_ptr_nxt_s;
            count_r     <= count_nxt_s;
            in_ready_r  <= in_ready_nxt_s;
            out_valid_r <= out_valid_nxt_s;
        end
    end

    // Storage write; a full buffer never accepts, so no entry is overwritten.
    always_ff @(posedge clock) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= in_bits;
        end
    end

    // First-word-fall-through read, forced to zero while empty so the
    // unreset storage never shows on the output.
    always_comb begin
        out_bits_s = {WIDTH{1'b0}};
        if (out_valid_r) begin
            out_bits_s = mem_r[rd_ptr_r];
        end else begin
            out_bits_s = {WIDTH{1'b0}};
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_bits  = out_bits_s;
    assign count     = count_r;

endmodule

// File: tb/tb_leaf_stream_fifo.sv
`timescale 1ns/1ps
module tb_leaf_stream_fifo;

    localparam int WIDTH = 3;
    localparam int DEPTH = 4;

    logic             clock;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_bits;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_bits;
    logic [2:0]       count;

    int checks;
    int failures;

    // Reference model: the stored words in arrival order.
    logic [WIDTH-1:0] model_q[$];
    // Words the DUT handed over (sampled just before each edge with out_valid & out_ready).
    logic [WIDTH-1:0] dut_log[$];

    leaf_stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bits   (in_bits),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bits  (out_bits),
        .count     (count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic compare_state(input string tag);
        check({tag, ".count"}, 32'(count), 32'(model_q.size()));
        check({tag, ".out_valid"}, 32'(out_valid), 32'(model_q.size() != 0));
        check({tag, ".in_ready"}, 32'(in_ready), 32'(model_q.size() != DEPTH));
        if (model_q.size() != 0) begin
            check({tag, ".out_bits"}, 32'(out_bits), 32'(model_q[0]));
        end
    endtask

    // One clock cycle: drive inputs, let the model follow the handshake rules, compare after the edge.
    task automatic step(input string tag, input logic v, input logic [WIDTH-1:0] d, input logic r,
                        output logic accepted);
        logic do_push;
        logic do_pop;
        in_valid  = v;
        in_bits   = d;
        out_ready = r;
        #1;
        if (out_valid && out_ready) dut_log.push_back(out_bits);
        do_push = v && (model_q.size() < DEPTH);
        do_pop  = r && (model_q.size() > 0);
        @(posedge clock);
        if (do_pop) void'(model_q.pop_front());
        if (do_push) model_q.push_back(d);
        accepted = do_push;
        #1;
        compare_state(tag);
    endtask

    initial begin
        logic acc;
        logic [WIDTH-1:0] seq[10];
        int idx;
        int budget;

        checks    = 0;
        failures  = 0;
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_bits   = '0;
        out_ready = 1'b0;
        void'($urandom(32'd20240611));

        // 1. Reset held for two cycles.
        repeat (2) @(posedge clock);
        #1;
        check("rst.count", 32'(count), 32'd0);
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.in_ready", 32'(in_ready), 32'd1);
        check("rst.out_bits", 32'(out_bits), 32'd0);
        reset = 1'b1;

        // 2. Single word.
        step("single.push", 1'b1, 3'b101, 1'b0, acc);
        check("single.out_bits5", 32'(out_bits), 32'd5);
        step("single.pop", 1'b0, 3'b000, 1'b1, acc);
        check("single.empty", 32'(out_valid), 32'd0);

        // 3. Fill, stall with 7 offered, then drain.
        for (int i = 1; i <= 4; i++) step("fill.push", 1'b1, 3'(i), 1'b0, acc);
        check("fill.full_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 3; i++) step("fill.stall", 1'b1, 3'd7, 1'b0, acc);
        check("fill.stall_count", 32'(count), 32'd4);
        dut_log.delete();
        for (int i = 0; i < 4; i++) step("fill.drain", 1'b0, 3'd0, 1'b1, acc);
        check("fill.drain_len", 32'(dut_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < dut_log.size(); i++)
            check("fill.drain_order", 32'(dut_log[i]), 32'(i + 1));

        // 4. Wrap-around stream with random back-pressure.
        for (int i = 0; i < 10; i++) seq[i] = 3'(i % 8);
        dut_log.delete();
        idx    = 0;
        budget = 0;
        while (idx < 10 && budget < 300) begin
            step("wrap.stream", 1'b1, seq[idx], 1'($urandom_range(0, 1)), acc);
            if (acc) idx++;
            budget++;
        end
        check("wrap.all_pushed", 32'(idx), 32'd10);
        in_valid = 1'b0;
        budget = 0;
        while (model_q.size() != 0 && budget < 50) begin
            step("wrap.drain", 1'b0, 3'd0, 1'b1, acc);
            budget++;
        end
        check("wrap.drained", 32'(model_q.size()), 32'd0);
        check("wrap.out_len", 32'(dut_log.size()), 32'd10);
        for (int i = 0; i < 10 && i < dut_log.size(); i++)
            check("wrap.order", 32'(dut_log[i]), 32'(seq[i]));

        // 5. Simultaneous push and pop at count 2, then at count 0.
        step("sim.fill", 1'b1, 3'd3, 1'b0, acc);
        step("sim.fill", 1'b1, 3'd6, 1'b0, acc);
        step("sim.both", 1'b1, 3'd1, 1'b1, acc);
        check("sim.count2", 32'(count), 32'd2);
        check("sim.head_adv", 32'(out_bits), 32'd6);
        step("sim.drain", 1'b0, 3'd0, 1'b1, acc);
        step("sim.drain", 1'b0, 3'd0, 1'b1, acc);
        check("sim.empty", 32'(count), 32'd0);
        step("sim.empty_both", 1'b1, 3'd4, 1'b1, acc);
        check("sim.empty_count1", 32'(count), 32'd1);
        check("sim.empty_head", 32'(out_bits), 32'd4);
        step("sim.clean", 1'b0, 3'd0, 1'b1, acc);

        // 6. Asynchronous reset mid-cycle with three words stored.
        for (int i = 0; i < 3; i++) step("ar.fill", 1'b1, 3'(i + 2), 1'b0, acc);
        check("ar.count3", 32'(count), 32'd3);
        in_valid = 1'b0;
        #3;
        reset = 1'b0;
        #1;
        model_q.delete();
        check("ar.count0", 32'(count), 32'd0);
        check("ar.out_valid0", 32'(out_valid), 32'd0);
        check("ar.in_ready1", 32'(in_ready), 32'd1);
        @(posedge clock);
        #1;
        reset = 1'b1;
        dut_log.delete();
        step("ar.push6", 1'b1, 3'd6, 1'b0, acc);
        step("ar.pop6", 1'b0, 3'd0, 1'b1, acc);
        check("ar.first_len", 32'(dut_log.size()), 32'd1);
        if (dut_log.size() != 0) check("ar.first_word", 32'(dut_log[0]), 32'd6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
